// File: rtl/cacheline_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_adapter
//
// Bridges the data cache's 256-bit line port to a 64-bit burst memory port.
// A write-back line is serialised into four 64-bit beats (lowest beat first);
// a read burst returns four 64-bit beats that are assembled into one line.
// Every completed line transaction ends with a single-cycle dfp_resp pulse.
//
// Ports
//   clk          sole clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   dfp_addr     line address from the cache (bits [4:0] ignored)
//   dfp_read     line read request, held by the cache until dfp_resp
//   dfp_write    line write request, held by the cache until dfp_resp
//   dfp_wdata    256-bit line to write back, valid with dfp_write
//   dfp_rdata    assembled 256-bit line, valid in the dfp_resp cycle of a read
//   dfp_resp     one-cycle completion pulse
//   bmem_addr    line-aligned burst address
//   bmem_read    burst read command
//   bmem_write   burst write beat valid
//   bmem_wdata   current 64-bit write beat
//   bmem_ready   memory accepts the command / beat this cycle
//   bmem_rdata   returned 64-bit read beat
//   bmem_rvalid  bmem_rdata valid
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any bmem_* input to any output.
// -----------------------------------------------------------------------------
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,

    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,

    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int          BEATS     = 4;
    localparam int          BEAT_W    = 64;
    localparam logic [1:0]  LAST_BEAT = 2'd3;

    // Clearing the offset bits with a mask keeps every address bit in use
    // while producing the line-aligned address.
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    localparam logic [2:0]  ST_IDLE      = 3'd0;
    localparam logic [2:0]  ST_WRITE     = 3'd1;
    localparam logic [2:0]  ST_READ_REQ  = 3'd2;
    localparam logic [2:0]  ST_READ_WAIT = 3'd3;
    localparam logic [2:0]  ST_RESP      = 3'd4;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]   state_q,    state_d;
    logic [1:0]   beat_cnt_q, beat_cnt_d;
    logic [31:0]  addr_q,     addr_d;
    logic [255:0] wdata_q,    wdata_d;
    // line_q collects read beats as they arrive; rdata_q is the line presented
    // to the cache and only changes when a read burst completes, so dfp_rdata
    // stays stable between reads.
    logic [255:0] line_q,     line_d;
    logic [255:0] rdata_q,    rdata_d;

    logic         beat_capture;
    logic         read_done;

    // A read beat is only taken while waiting for read data; stray rvalid in
    // any other state (including right after a reset) is ignored.
    assign beat_capture = (state_q == ST_READ_WAIT) && bmem_rvalid;
    assign read_done    = beat_capture && (beat_cnt_q == LAST_BEAT);

    // -------------------------------------------------------------------------
    // Beat lanes
    // -------------------------------------------------------------------------
    logic [BEAT_W-1:0] wr_lane [BEATS];

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
            // Write side: slice of the latched line, beat 0 is the lowest.
            assign wr_lane[gi] = wdata_q[BEAT_W*gi +: BEAT_W];

            // Read side: a lane is overwritten only by the beat whose count
            // matches its position, giving ascending-address assembly.
            assign line_d[BEAT_W*gi +: BEAT_W] =
                (beat_capture && (beat_cnt_q == 2'(gi))) ? bmem_rdata
                                                         : line_q[BEAT_W*gi +: BEAT_W];
        end
    endgenerate

    // The final beat is already merged into line_d, so the completed line can
    // be published in the same cycle it finishes.
    assign rdata_d = read_done ? line_d : rdata_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_IDLE: begin
                // Write-back wins when both requests are raised together.
                if (dfp_write) begin
                    addr_d     = dfp_addr & LINE_MASK;
                    wdata_d    = dfp_wdata;
                    beat_cnt_d = 2'd0;
                    state_d    = ST_WRITE;
                end else if (dfp_read) begin
                    addr_d     = dfp_addr & LINE_MASK;
                    beat_cnt_d = 2'd0;
                    state_d    = ST_READ_REQ;
                end
            end

            ST_WRITE: begin
                // Without ready the current beat and its data are simply held.
                if (bmem_ready) begin
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_READ_REQ: begin
                if (bmem_ready) begin
                    state_d = ST_READ_WAIT;
                end
            end

            ST_READ_WAIT: begin
                if (bmem_rvalid) begin
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                // The cache still holds its request during this cycle; going
                // straight back to IDLE without sampling it prevents a repeat.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= '0;
            line_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            line_q     <= line_d;
            rdata_q    <= rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: state decodes and registered values only
    // -------------------------------------------------------------------------
    assign dfp_resp   = (state_q == ST_RESP);
    assign dfp_rdata  = rdata_q;
    assign bmem_read  = (state_q == ST_READ_REQ);
    assign bmem_write = (state_q == ST_WRITE);
    assign bmem_addr  = addr_q;
    assign bmem_wdata = (state_q == ST_WRITE) ? wr_lane[beat_cnt_q] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adapter
//
// Directed bench for cacheline_adapter. Inputs are driven and outputs are
// sampled on the falling edge, so each falling edge observes the registered
// state of the current cycle and sets up the inputs sampled by the next
// rising edge. Expected values are hand-written constants.
// -----------------------------------------------------------------------------
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Event counters sampled at the rising edge (values of the ending cycle).
    int resp_cnt   = 0;
    int rdcmd_cnt  = 0;
    int wrbeat_cnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (dfp_resp)                resp_cnt   <= resp_cnt + 1;
            if (bmem_read && bmem_ready) rdcmd_cnt  <= rdcmd_cnt + 1;
            if (bmem_write && bmem_ready) wrbeat_cnt <= wrbeat_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Stimulus constants
    logic [63:0]  wb1 [4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                              64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    logic [63:0]  wb2 [4] = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                              64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
    logic [63:0]  rb1 [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    logic [63:0]  rb2 [4] = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                              64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    logic [63:0]  rb3 [4] = '{64'h9999_0000_0000_0009, 64'h9999_0000_0000_0019,
                              64'h9999_0000_0000_0029, 64'h9999_0000_0000_0039};
    logic [255:0] line_w1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    logic [255:0] line_w2 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                             64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    logic [255:0] line_r1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    logic [255:0] line_r2 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                             64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    logic [255:0] line_r3 = {64'h9999_0000_0000_0039, 64'h9999_0000_0000_0029,
                             64'h9999_0000_0000_0019, 64'h9999_0000_0000_0009};

    initial begin
        int rd0;
        int rs0;
        int wr0;
        int idx;
        int bp_beat [6] = '{0, 1, 2, 2, 2, 3};
        logic rv_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst         = 1'b1;
        dfp_addr    = 32'd0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_rdata  = 64'd0;
        bmem_rvalid = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_resp",   256'(dfp_resp),   256'(0));
        check("rst_bread",  256'(bmem_read),  256'(0));
        check("rst_bwrite", 256'(bmem_write), 256'(0));
        check("rst_baddr",  256'(bmem_addr),  256'(0));
        check("rst_bwdata", 256'(bmem_wdata), 256'(0));
        check("rst_rdata",  dfp_rdata,        256'(0));
        $display("txn reset: done");
        rst = 1'b0;
        tick();

        // ---------------- write, ready always high ----------------
        dfp_addr   = 32'h1234_5678;
        dfp_wdata  = line_w1;
        dfp_write  = 1'b1;
        bmem_ready = 1'b1;
        check("w1_idle_resp", 256'(dfp_resp), 256'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("w1_bwrite", 256'(bmem_write), 256'(1));
            check("w1_bread",  256'(bmem_read),  256'(0));
            check("w1_addr",   256'(bmem_addr),  256'(32'h1234_5660));
            check("w1_beat",   256'(bmem_wdata), 256'(wb1[k]));
            check("w1_noresp", 256'(dfp_resp),   256'(0));
        end
        tick();
        check("w1_resp",    256'(dfp_resp),   256'(1));
        check("w1_wr_off",  256'(bmem_write), 256'(0));
        tick();
        dfp_write = 1'b0;
        check("w1_resp_one", 256'(dfp_resp), 256'(0));
        tick();
        check("w1_no_reaccept", 256'(bmem_write), 256'(0));
        $display("txn write addr=12345678: done");

        // ---------------- write with backpressure ----------------
        dfp_addr   = 32'h0000_1020;
        dfp_wdata  = line_w2;
        dfp_write  = 1'b1;
        bmem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            bmem_ready = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            check("w2_bwrite", 256'(bmem_write), 256'(1));
            check("w2_beat",   256'(bmem_wdata), 256'(wb2[bp_beat[k]]));
            check("w2_noresp", 256'(dfp_resp),   256'(0));
        end
        tick();
        check("w2_resp", 256'(dfp_resp), 256'(1));
        tick();
        dfp_write  = 1'b0;
        bmem_ready = 1'b1;
        $display("txn write backpressure addr=00001020: done");

        // ---------------- read with gapped beats ----------------
        rd0 = rdcmd_cnt;
        dfp_addr = 32'h8000_0040;
        dfp_read = 1'b1;
        tick();
        check("r1_bread",  256'(bmem_read),  256'(1));
        check("r1_addr",   256'(bmem_addr),  256'(32'h8000_0040));
        check("r1_bwrite", 256'(bmem_write), 256'(0));
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            bmem_rvalid = rv_pat[c];
            if (rv_pat[c]) begin
                bmem_rdata = rb1[idx];
                idx++;
            end else begin
                bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            check("r1_bread_off", 256'(bmem_read), 256'(0));
            check("r1_noresp",    256'(dfp_resp),  256'(0));
            if (c == 6) check("r1_rdata_held", dfp_rdata, 256'(0));
        end
        tick();
        bmem_rvalid = 1'b0;
        check("r1_resp",  256'(dfp_resp), 256'(1));
        check("r1_rdata", dfp_rdata,       line_r1);
        check("r1_ncmd",  256'(rdcmd_cnt - rd0), 256'(1));
        tick();
        dfp_read = 1'b0;
        check("r1_resp_one", 256'(dfp_resp), 256'(0));
        $display("txn read addr=80000040: done");

        // ---------------- write-back then allocate ----------------
        tick();
        rd0 = rdcmd_cnt;
        rs0 = resp_cnt;
        wr0 = wrbeat_cnt;
        dfp_addr  = 32'h0000_4000;
        dfp_wdata = line_w1;
        dfp_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("b2b_bwrite", 256'(bmem_write), 256'(1));
        end
        tick();
        check("b2b_wresp", 256'(dfp_resp), 256'(1));
        tick();
        dfp_write = 1'b0;
        dfp_read  = 1'b1;
        dfp_addr  = 32'h0000_5000;
        check("b2b_gap_bwrite", 256'(bmem_write), 256'(0));
        check("b2b_gap_bread",  256'(bmem_read),  256'(0));
        tick();
        check("b2b_bread", 256'(bmem_read), 256'(1));
        check("b2b_addr",  256'(bmem_addr), 256'(32'h0000_5000));
        for (int k = 0; k < 4; k++) begin
            tick();
            bmem_rvalid = 1'b1;
            bmem_rdata  = rb2[k];
            check("b2b_noresp", 256'(dfp_resp), 256'(0));
        end
        tick();
        bmem_rvalid = 1'b0;
        check("b2b_rresp", 256'(dfp_resp), 256'(1));
        check("b2b_rdata", dfp_rdata,       line_r2);
        tick();
        dfp_read = 1'b0;
        tick();
        check("b2b_nresp",  256'(resp_cnt - rs0),   256'(2));
        check("b2b_ncmd",   256'(rdcmd_cnt - rd0),  256'(1));
        check("b2b_nbeats", 256'(wrbeat_cnt - wr0), 256'(4));
        $display("txn write-back 00004000 then allocate 00005000: done");

        // ---------------- reset after two read beats ----------------
        dfp_addr = 32'h0000_9000;
        dfp_read = 1'b1;
        tick();
        check("rr_bread", 256'(bmem_read), 256'(1));
        tick();
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'hAAAA_0000_0000_0001;
        tick();
        bmem_rdata  = 64'hAAAA_0000_0000_0002;
        tick();
        bmem_rvalid = 1'b0;
        rst         = 1'b1;
        dfp_read    = 1'b0;
        tick();
        rst = 1'b0;
        check("rr_resp",   256'(dfp_resp),   256'(0));
        check("rr_bread0", 256'(bmem_read),  256'(0));
        check("rr_bwrite", 256'(bmem_write), 256'(0));
        check("rr_baddr",  256'(bmem_addr),  256'(0));
        check("rr_bwdata", 256'(bmem_wdata), 256'(0));
        check("rr_rdata",  dfp_rdata,        256'(0));
        rs0 = resp_cnt;
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'hAAAA_0000_0000_0003;
        tick();
        bmem_rdata  = 64'hAAAA_0000_0000_0004;
        tick();
        bmem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_late_noresp", 256'(dfp_resp), 256'(0));
        end
        check("rr_nresp", 256'(resp_cnt - rs0), 256'(0));
        dfp_addr = 32'h0000_A01F;
        dfp_read = 1'b1;
        tick();
        check("rr2_bread", 256'(bmem_read), 256'(1));
        check("rr2_addr",  256'(bmem_addr), 256'(32'h0000_A000));
        for (int k = 0; k < 4; k++) begin
            tick();
            bmem_rvalid = 1'b1;
            bmem_rdata  = rb3[k];
        end
        tick();
        bmem_rvalid = 1'b0;
        check("rr2_resp",  256'(dfp_resp), 256'(1));
        check("rr2_rdata", dfp_rdata,       line_r3);
        tick();
        dfp_read = 1'b0;
        $display("txn reset mid-read then read addr=0000A000: done");

        // ---------------- stray rvalid, simultaneous requests ----------------
        tick();
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("st_noresp", 256'(dfp_resp),  256'(0));
            check("st_bread",  256'(bmem_read), 256'(0));
        end
        bmem_rvalid = 1'b0;
        dfp_addr  = 32'h0000_B000;
        dfp_wdata = line_w2;
        dfp_read  = 1'b1;
        dfp_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("st_bwrite", 256'(bmem_write), 256'(1));
            check("st_bread0", 256'(bmem_read),  256'(0));
            check("st_beat",   256'(bmem_wdata), 256'(wb2[k]));
        end
        tick();
        check("st_resp",  256'(dfp_resp), 256'(1));
        check("st_rdata", dfp_rdata,       line_r3);
        tick();
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        tick();
        check("st_idle_bread",  256'(bmem_read),  256'(0));
        check("st_idle_bwrite", 256'(bmem_write), 256'(0));
        $display("txn stray rvalid + simultaneous read/write addr=0000B000: done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
